// File: rtl/mtsp_sync_pkg.sv
// mtsp_sync_pkg: shared types for the MTSP multi-barrier sync controller.
// Holds the per-slot FSM state encoding and the barrier-ID width helper.
package mtsp_sync_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        RELEASE,
        TIMEOUT
    } state_t;

    // Barrier-ID width; a single barrier still gets a 1-bit ID field.
    function automatic int calc_idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mtsp_sync_barrier_slot.sv
// mtsp_sync_barrier_slot: one barrier (participant mask, arrival set,
// watchdog counter, FSM) with registered per-core ack/err pulses.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   en_i            sync requests already decoded to this barrier
//   cfg_we_i        mask write for this barrier (honoured only in IDLE)
//   cfg_mask_i      new participant mask
//   cfg_timeout_i   watchdog limit, 0 = off
//   mask_o          current participant mask
//   ack_o, err_o    registered release pulses
//   tmo_set_o       high in the cycle the slot commits to TIMEOUT
//   busy_o          slot not IDLE
import mtsp_sync_pkg::*;

module mtsp_sync_barrier_slot #(
    parameter int CORE_SIZE = 4,
    parameter int TMO_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [CORE_SIZE-1:0] en_i,
    input  logic                 cfg_we_i,
    input  logic [CORE_SIZE-1:0] cfg_mask_i,
    input  logic [TMO_WIDTH-1:0] cfg_timeout_i,
    output logic [CORE_SIZE-1:0] mask_o,
    output logic [CORE_SIZE-1:0] ack_o,
    output logic [CORE_SIZE-1:0] err_o,
    output logic                 tmo_set_o,
    output logic                 busy_o
);

    state_t               state_q;
    logic [CORE_SIZE-1:0] mask_q;
    logic [CORE_SIZE-1:0] arrived_q;
    logic [TMO_WIDTH-1:0] cnt_q;
    logic [CORE_SIZE-1:0] ack_q;
    logic [CORE_SIZE-1:0] err_q;

    logic [CORE_SIZE-1:0] part_en;
    logic [CORE_SIZE-1:0] tmo_rel;
    logic                 all_in;
    logic                 tmo_hit;
    logic [TMO_WIDTH-1:0] cnt_d;

    // Requests from cores outside the mask are handled by the top.
    assign part_en = en_i & mask_q;
    assign all_in  = (arrived_q == mask_q);
    assign tmo_hit = (cfg_timeout_i != '0) &&
                     (cnt_q == cfg_timeout_i - TMO_WIDTH'(1));
    // Saturating counter: a stuck barrier must not wrap back below the limit.
    assign cnt_d   = (&cnt_q) ? cnt_q : cnt_q + TMO_WIDTH'(1);
    // A core arriving in the very cycle the watchdog fires is released too.
    assign tmo_rel = arrived_q | part_en;

    assign tmo_set_o = (state_q == COLLECT) && !all_in && tmo_hit;
    assign busy_o    = (state_q != IDLE);
    assign mask_o    = mask_q;
    assign ack_o     = ack_q;
    assign err_o     = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            arrived_q <= '0;
            cnt_q     <= '0;
            ack_q     <= '0;
            err_q     <= '0;
        end else begin
            ack_q <= '0;
            err_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (cfg_we_i) begin
                        mask_q <= cfg_mask_i;
                    end
                    if (|part_en) begin
                        arrived_q <= part_en;
                        cnt_q     <= '0;
                        state_q   <= COLLECT;
                    end
                end
                COLLECT: begin
                    cnt_q <= cnt_d;
                    if (all_in) begin
                        ack_q   <= mask_q;
                        state_q <= RELEASE;
                    end else if (tmo_hit) begin
                        ack_q     <= tmo_rel;
                        err_q     <= tmo_rel;
                        arrived_q <= '0;
                        state_q   <= TIMEOUT;
                    end else begin
                        arrived_q <= arrived_q | part_en;
                    end
                end
                RELEASE, TIMEOUT: begin
                    // Arrivals here open the next generation.
                    arrived_q <= part_en;
                    cnt_q     <= '0;
                    state_q   <= (|part_en) ? COLLECT : IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/mtsp_sync_barrier_ctrl.sv
// mtsp_sync_barrier_ctrl: multi-barrier sync scheduler for the MTSP cluster.
// Decodes tagged core sync pulses onto BARRIER_COUNT slots and merges acks.
// Ports:
//   CLK, nRST          clock, async active-low reset
//   sync_en/sync_id    per-core request pulse and barrier ID
//   sync_ack/sync_err  per-core release pulse, err marks abnormal release
//   cfg_we/cfg_id/cfg_mask  participant mask write; cfg_err flags rejection
//   cfg_timeout        watchdog limit in cycles, 0 = off
//   status_clr         W1C for tmo_status; irq = |tmo_status
//   barrier_busy       per-barrier not-IDLE
import mtsp_sync_pkg::*;

module mtsp_sync_barrier_ctrl #(
    parameter  int CORE_SIZE     = 4,
    parameter  int BARRIER_COUNT = 4,
    parameter  int TMO_WIDTH     = 16,
    localparam int IDW           = calc_idw(BARRIER_COUNT)
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [CORE_SIZE-1:0]     sync_en,
    input  logic [CORE_SIZE*IDW-1:0] sync_id,
    output logic [CORE_SIZE-1:0]     sync_ack,
    output logic [CORE_SIZE-1:0]     sync_err,
    input  logic                     cfg_we,
    input  logic [IDW-1:0]           cfg_id,
    input  logic [CORE_SIZE-1:0]     cfg_mask,
    input  logic [TMO_WIDTH-1:0]     cfg_timeout,
    output logic                     cfg_err,
    input  logic [BARRIER_COUNT-1:0] status_clr,
    output logic [BARRIER_COUNT-1:0] tmo_status,
    output logic                     irq,
    output logic [BARRIER_COUNT-1:0] barrier_busy
);

    logic [CORE_SIZE-1:0]     slot_en   [BARRIER_COUNT];
    logic [CORE_SIZE-1:0]     slot_mask [BARRIER_COUNT];
    logic [CORE_SIZE-1:0]     slot_ack  [BARRIER_COUNT];
    logic [CORE_SIZE-1:0]     slot_err  [BARRIER_COUNT];
    logic [BARRIER_COUNT-1:0] slot_we;
    logic [BARRIER_COUNT-1:0] slot_tmo;
    logic [BARRIER_COUNT-1:0] slot_busy;

    logic [CORE_SIZE-1:0]     part_hit;
    logic [CORE_SIZE-1:0]     ack_or;
    logic [CORE_SIZE-1:0]     err_or;

    logic [CORE_SIZE-1:0]     np_d;
    logic [CORE_SIZE-1:0]     np_q;
    logic                     cfg_err_d;
    logic                     cfg_err_q;
    logic [BARRIER_COUNT-1:0] tmo_d;
    logic [BARRIER_COUNT-1:0] tmo_q;

    // ID decode: one request vector per barrier, plus the mask write strobe.
    always_comb begin
        for (int b = 0; b < BARRIER_COUNT; b++) begin
            slot_we[b] = cfg_we && (cfg_id == IDW'(b));
            slot_en[b] = '0;
            for (int i = 0; i < CORE_SIZE; i++) begin
                slot_en[b][i] = sync_en[i] &&
                                (sync_id[i*IDW +: IDW] == IDW'(b));
            end
        end
    end

    // A request no slot accepts (mask bit 0, or an ID with no slot)
    // is bounced back with ack+err one cycle later.
    always_comb begin
        part_hit = '0;
        for (int b = 0; b < BARRIER_COUNT; b++) begin
            part_hit = part_hit | (slot_en[b] & slot_mask[b]);
        end
        np_d = sync_en & ~part_hit;
    end

    always_comb begin
        ack_or = '0;
        err_or = '0;
        for (int b = 0; b < BARRIER_COUNT; b++) begin
            ack_or = ack_or | slot_ack[b];
            err_or = err_or | slot_err[b];
        end
    end

    assign cfg_err_d = cfg_we && |(slot_we & slot_busy);
    // A timeout set in the same cycle as a clear wins.
    assign tmo_d     = (tmo_q & ~status_clr) | slot_tmo;

    for (genvar b = 0; b < BARRIER_COUNT; b++) begin : g_slot
        mtsp_sync_barrier_slot #(
            .CORE_SIZE (CORE_SIZE),
            .TMO_WIDTH (TMO_WIDTH)
        ) u_slot (
            .clk_i         (CLK),
            .rst_ni        (nRST),
            .en_i          (slot_en[b]),
            .cfg_we_i      (slot_we[b]),
            .cfg_mask_i    (cfg_mask),
            .cfg_timeout_i (cfg_timeout),
            .mask_o        (slot_mask[b]),
            .ack_o         (slot_ack[b]),
            .err_o         (slot_err[b]),
            .tmo_set_o     (slot_tmo[b]),
            .busy_o        (slot_busy[b])
        );
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            np_q      <= '0;
            cfg_err_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            np_q      <= np_d;
            cfg_err_q <= cfg_err_d;
            tmo_q     <= tmo_d;
        end
    end

    assign sync_ack     = ack_or | np_q;
    assign sync_err     = err_or | np_q;
    assign cfg_err      = cfg_err_q;
    assign tmo_status   = tmo_q;
    assign irq          = |tmo_q;
    assign barrier_busy = slot_busy;

endmodule

// File: tb/tb_mtsp_sync_barrier_ctrl.sv
// tb_mtsp_sync_barrier_ctrl: directed scenarios followed by a randomized
// run scored against a transaction-level barrier model.
module tb_mtsp_sync_barrier_ctrl;

    localparam int N   = 600;
    localparam int TO  = 12;
    localparam int INF = 1 << 30;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [3:0]  sync_en;
    logic [7:0]  sync_id;
    logic [3:0]  sync_ack;
    logic [3:0]  sync_err;
    logic        cfg_we;
    logic [1:0]  cfg_id;
    logic [3:0]  cfg_mask;
    logic [15:0] cfg_timeout;
    logic        cfg_err;
    logic [3:0]  status_clr;
    logic [3:0]  tmo_status;
    logic        irq;
    logic [3:0]  barrier_busy;

    int checks = 0;
    int errors = 0;

    // model state for the random phase
    logic [3:0] m      [4];
    logic [3:0] e_ack  [0:N+3];
    logic [3:0] e_err  [0:N+3];
    logic [3:0] e_set  [0:N+3];
    int         rel    [4];
    logic       act    [4];
    int         st     [4];
    logic [3:0] arr    [4];
    int         blk    [4];
    logic [3:0] tmo_m;
    logic [3:0] clr_prev;
    logic [3:0] clr;
    int         b;

    always #5 CLK = ~CLK;

    mtsp_sync_barrier_ctrl #(
        .CORE_SIZE     (4),
        .BARRIER_COUNT (4),
        .TMO_WIDTH     (16)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .sync_en      (sync_en),
        .sync_id      (sync_id),
        .sync_ack     (sync_ack),
        .sync_err     (sync_err),
        .cfg_we       (cfg_we),
        .cfg_id       (cfg_id),
        .cfg_mask     (cfg_mask),
        .cfg_timeout  (cfg_timeout),
        .cfg_err      (cfg_err),
        .status_clr   (status_clr),
        .tmo_status   (tmo_status),
        .irq          (irq),
        .barrier_busy (barrier_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic cfg(input logic [1:0] id, input logic [3:0] msk,
                       input logic exp_err);
        cfg_we   = 1'b1;
        cfg_id   = id;
        cfg_mask = msk;
        tick();
        cfg_we   = 1'b0;
        chk("cfg_err", 32'(cfg_err), 32'(exp_err));
    endtask

    initial begin
        sync_en     = '0;
        sync_id     = '0;
        cfg_we      = 1'b0;
        cfg_id      = '0;
        cfg_mask    = '0;
        cfg_timeout = '0;
        status_clr  = '0;
        nRST        = 1'b0;
        repeat (3) tick();
        chk("rst_ack", 32'(sync_ack), 0);
        chk("rst_err", 32'(sync_err), 0);
        chk("rst_busy", 32'(barrier_busy), 0);
        chk("rst_tmo", 32'(tmo_status), 0);
        chk("rst_irq", 32'(irq), 0);
        nRST = 1'b1;
        tick();
        cfg(2'd0, 4'hF, 1'b0);
        cfg(2'd1, 4'h5, 1'b0);
        cfg(2'd2, 4'h3, 1'b0);

        // 1: all cores on barrier 0 in one cycle
        sync_en = 4'hF;
        sync_id = 8'h00;
        tick();
        sync_en = '0;
        chk("t1_ack_T1", 32'(sync_ack), 0);
        chk("t1_busy_T1", 32'(barrier_busy), 32'h1);
        tick();
        chk("t1_ack_T2", 32'(sync_ack), 32'hF);
        chk("t1_err_T2", 32'(sync_err), 0);
        chk("t1_busy_T2", 32'(barrier_busy), 32'h1);
        tick();
        chk("t1_ack_T3", 32'(sync_ack), 0);
        chk("t1_busy_T3", 32'(barrier_busy), 0);

        // 2: staggered arrivals on barrier 1 with a duplicate
        sync_en = 4'h1;
        sync_id = 8'h01;
        tick();
        sync_en = '0;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("t2_ack_T%0d", k), 32'(sync_ack),
                (k == 7) ? 32'h5 : 32'h0);
            chk($sformatf("t2_err_T%0d", k), 32'(sync_err), 0);
            if (k == 3) begin
                sync_en = 4'h1;
                sync_id = 8'h01;
            end
            if (k == 5) begin
                sync_en = 4'h4;
                sync_id = 8'h10;
            end
            tick();
            sync_en = '0;
        end

        // 3: watchdog on barrier 2
        cfg_timeout = 16'd10;
        sync_en = 4'h2;
        sync_id = 8'h08;
        tick();
        sync_en = '0;
        for (int k = 1; k <= 11; k++) begin
            chk($sformatf("t3_ack_T%0d", k), 32'(sync_ack),
                (k == 11) ? 32'h2 : 32'h0);
            chk($sformatf("t3_err_T%0d", k), 32'(sync_err),
                (k == 11) ? 32'h2 : 32'h0);
            if (k != 11) tick();
        end
        tick();
        chk("t3_tmo", 32'(tmo_status), 32'h4);
        chk("t3_irq", 32'(irq), 1);
        chk("t3_ack_after", 32'(sync_ack), 0);
        status_clr = 4'h4;
        tick();
        status_clr = '0;
        chk("t3_tmo_clr", 32'(tmo_status), 0);
        chk("t3_irq_clr", 32'(irq), 0);
        cfg_timeout = '0;

        // 4: non-participant on disabled barrier 3
        sync_en = 4'h8;
        sync_id = 8'hC0;
        tick();
        sync_en = '0;
        chk("t4_ack", 32'(sync_ack), 32'h8);
        chk("t4_err", 32'(sync_err), 32'h8);
        chk("t4_busy", 32'(barrier_busy), 0);
        tick();
        chk("t4_ack_after", 32'(sync_ack), 0);
        chk("t4_busy_after", 32'(barrier_busy), 0);

        // 5: rejected cfg write, then two barriers finishing together
        sync_en = 4'h1;
        sync_id = 8'h00;
        tick();
        sync_en = '0;
        cfg(2'd0, 4'h1, 1'b1);
        tick();
        chk("t5_cfg_err_end", 32'(cfg_err), 0);
        chk("t5_ack_hold1", 32'(sync_ack), 0);
        tick();
        chk("t5_ack_hold2", 32'(sync_ack), 0);
        sync_en = 4'hE;
        sync_id = 8'h00;
        tick();
        sync_en = '0;
        chk("t5_ack_T1", 32'(sync_ack), 0);
        tick();
        chk("t5_ack_full", 32'(sync_ack), 32'hF);
        chk("t5_err_full", 32'(sync_err), 0);
        tick();
        cfg(2'd0, 4'h3, 1'b0);
        cfg(2'd1, 4'hC, 1'b0);
        sync_en = 4'hF;
        sync_id = 8'h50;
        tick();
        sync_en = '0;
        chk("t5_dual_T1", 32'(sync_ack), 0);
        tick();
        chk("t5_dual_ack", 32'(sync_ack), 32'hF);
        chk("t5_dual_err", 32'(sync_err), 0);
        chk("t5_dual_busy", 32'(barrier_busy), 32'h3);
        tick();
        chk("t5_dual_after", 32'(sync_ack), 0);

        // 6: reset in the middle of a collection
        cfg(2'd0, 4'hF, 1'b0);
        sync_en = 4'h1;
        sync_id = 8'h00;
        tick();
        sync_en = '0;
        chk("t6_busy", 32'(barrier_busy), 32'h1);
        #1 nRST = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(barrier_busy), 0);
        chk("t6_rst_ack", 32'(sync_ack), 0);
        tick();
        nRST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_no_ack", 32'(sync_ack), 0);
        end
        cfg(2'd0, 4'hF, 1'b0);
        sync_en = 4'hF;
        sync_id = 8'h00;
        tick();
        sync_en = '0;
        chk("t6_ack_T1", 32'(sync_ack), 0);
        tick();
        chk("t6_ack_T2", 32'(sync_ack), 32'hF);
        chk("t6_err_T2", 32'(sync_err), 0);
        tick();

        // random phase
        for (int i = 0; i < 4; i++) begin
            m[i] = 4'($urandom_range(0, 15));
            cfg(2'(i), m[i], 1'b0);
        end
        cfg_timeout = 16'(TO);
        status_clr = 4'hF;
        tick();
        status_clr = '0;
        tick();
        for (int c = 0; c < N + 4; c++) begin
            e_ack[c] = '0;
            e_err[c] = '0;
            e_set[c] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            rel[i] = 0;
            act[i] = 1'b0;
            st[i]  = 0;
            arr[i] = '0;
            blk[i] = -1;
        end
        tmo_m    = '0;
        clr_prev = '0;
        for (int c = 0; c < N; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (act[k] && c == st[k] + TO) begin
                    e_ack[c+1] = e_ack[c+1] | arr[k];
                    e_err[c+1] = e_err[c+1] | arr[k];
                    e_set[c+1][k] = 1'b1;
                    for (int i = 0; i < 4; i++)
                        if (arr[k][i]) rel[i] = c + 1;
                    act[k] = 1'b0;
                    blk[k] = c + 1;
                end
            end
            tmo_m = (tmo_m & ~clr_prev) | e_set[c];
            chk($sformatf("rnd_ack_c%0d", c), 32'(sync_ack), 32'(e_ack[c]));
            chk($sformatf("rnd_err_c%0d", c), 32'(sync_err), 32'(e_err[c]));
            chk($sformatf("rnd_tmo_c%0d", c), 32'(tmo_status), 32'(tmo_m));
            chk($sformatf("rnd_irq_c%0d", c), 32'(irq), 32'(|tmo_m));
            sync_en = '0;
            sync_id = '0;
            for (int i = 0; i < 4; i++) begin
                if (rel[i] <= c && $urandom_range(0, 2) == 0) begin
                    b = int'($urandom_range(0, 3));
                    if (!m[b][i]) begin
                        sync_en[i] = 1'b1;
                        sync_id[i*2 +: 2] = 2'(b);
                        e_ack[c+1][i] = 1'b1;
                        e_err[c+1][i] = 1'b1;
                        rel[i] = c + 1;
                    end else if (c > blk[b]) begin
                        sync_en[i] = 1'b1;
                        sync_id[i*2 +: 2] = 2'(b);
                        if (!act[b]) begin
                            act[b] = 1'b1;
                            st[b]  = c;
                            arr[b] = '0;
                        end
                        arr[b][i] = 1'b1;
                        rel[i] = INF;
                        if (arr[b] == m[b]) begin
                            e_ack[c+2] = e_ack[c+2] | m[b];
                            for (int j = 0; j < 4; j++)
                                if (m[b][j]) rel[j] = c + 2;
                            act[b] = 1'b0;
                        end
                    end
                end
            end
            clr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            status_clr = clr;
            clr_prev   = clr;
            tick();
        end
        sync_en    = '0;
        status_clr = '0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
